fir_tap_sequencer: RTL and testbench

Front end of the FIR audio filter datapath, and the feeder for the multiply-accumulate unit. Accepts one audio sample per handshake, stores it in an 8-deep circular delay line, then streams 8 (sample, coefficient) pairs, one per cycle, to the MAC. It captures the finished accumulator value as the filter output. Coefficients are held in a local register file that can be written while the block is idle.

---
 rtl/fir_pkg.sv | 8 +
 rtl/fir_delay_line.sv | 30 +++
 rtl/fir_tap_sequencer.sv | 71 +++++++
 tb/tb_fir_tap_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and FSM state encoding for the FIR front end.
package fir_pkg;
  localparam int DATA_W = 21;
  localparam int ACC_W = 25;
  localparam int TAPS = 8;
  localparam int TAP_IDX_W = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample buffer read relative to the newest entry.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [TAP_IDX_W-1:0] i_idx,
  output logic [DATA_W-1:0]    o_rdata
);
  logic [DATA_W-1:0]    r_delay [TAPS];
  logic [TAP_IDX_W-1:0] r_wr_ptr;
  logic [TAP_IDX_W-1:0] r_newest;
  logic [TAP_IDX_W-1:0] w_rd_ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_delay[i] <= '0;
      r_wr_ptr <= '0;
      r_newest <= '0;
    end else if (i_we) begin
      r_delay[r_wr_ptr] <= i_wdata;
      r_newest          <= r_wr_ptr;
      r_wr_ptr          <= r_wr_ptr + 1'b1;
    end
  end
  // TAPS is a power of two, so index width truncation gives the modulo
  assign w_rd_ptr = r_newest - i_idx;
  assign o_rdata  = r_delay[w_rd_ptr];
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: streams sample/coefficient pairs to the MAC and captures its result.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 coef_we,
  input  logic [TAP_IDX_W-1:0] coef_addr,
  input  logic [DATA_W-1:0]    coef_data,
  output logic [DATA_W-1:0]    mac_a,
  output logic [DATA_W-1:0]    mac_b,
  output logic                 mac_clr,
  input  logic [ACC_W-1:0]     acc_in,
  output logic [ACC_W-1:0]     y_out,
  output logic                 y_valid
);
  state_t               r_state;
  logic [TAP_IDX_W-1:0] r_tap_idx;
  logic [DATA_W-1:0]    r_coef [TAPS];
  logic [ACC_W-1:0]     r_y_out;
  logic                 r_y_valid;
  logic                 w_idle;
  logic                 w_run;
  logic                 w_accept;
  logic [DATA_W-1:0]    w_sample;
  assign w_idle   = r_state == IDLE;
  assign w_run    = r_state == RUN;
  assign w_accept = w_idle && sample_valid;
  fir_delay_line u_delay (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_accept),
    .i_wdata (sample_in),
    .i_idx   (r_tap_idx),
    .o_rdata (w_sample)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tap_idx <= '0;
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_idle) begin
        if (coef_we) r_coef[coef_addr] <= coef_data;
        if (sample_valid) begin
          r_tap_idx <= '0;
          r_state   <= RUN;
        end
      end else if (w_run) begin
        r_tap_idx <= r_tap_idx + 1'b1;
        if (r_tap_idx == TAP_IDX_W'(TAPS - 1)) r_state <= DRAIN;
      end else begin
        r_y_out   <= acc_in;
        r_y_valid <= 1'b1;
        r_state   <= IDLE;
      end
    end
  end
  assign sample_ready = w_idle;
  assign mac_clr      = !w_run;
  assign mac_a        = w_run ? w_sample : '0;
  assign mac_b        = w_run ? r_coef[r_tap_idx] : '0;
  assign y_out        = r_y_out;
  assign y_valid      = r_y_valid;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed scenario tasks for the FIR tap sequencer.
module tb_fir_tap_sequencer;
  import fir_pkg::*;
  logic                 clk = 1'b0;
  logic                 reset;
  logic [DATA_W-1:0]    sample_in;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 coef_we;
  logic [TAP_IDX_W-1:0] coef_addr;
  logic [DATA_W-1:0]    coef_data;
  logic [DATA_W-1:0]    mac_a;
  logic [DATA_W-1:0]    mac_b;
  logic                 mac_clr;
  logic [ACC_W-1:0]     acc_in;
  logic [ACC_W-1:0]     y_out;
  logic                 y_valid;
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] hist [8];
  logic [DATA_W-1:0] exp_coef [8];
  fir_tap_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_clr      (mac_clr),
    .acc_in       (acc_in),
    .y_out        (y_out),
    .y_valid      (y_valid)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_outputs(input string tag, input logic [ACC_W-1:0] exp_y, input logic exp_v);
    checks++;
    if ({sample_ready, mac_clr, mac_a, mac_b, y_out, y_valid} !== {1'b1, 1'b1, {DATA_W{1'b0}}, {DATA_W{1'b0}}, exp_y, exp_v}) begin
      failures++;
      $display("FAIL %s: ready=%b clr=%b a=%0d b=%0d y=%h yv=%b, expected ready=1 clr=1 a=0 b=0 y=%h yv=%b",
               tag, sample_ready, mac_clr, mac_a, mac_b, y_out, y_valid, exp_y, exp_v);
    end
  endtask
  task automatic frame(input logic [DATA_W-1:0] s, input logic [ACC_W-1:0] acc,
                       input bit hold, input bit idle_we, input bit run_we, input string tag);
    sample_in = s;
    sample_valid = 1'b1;
    if (idle_we) begin
      coef_we = 1'b1; coef_addr = 3'd3; coef_data = 21'd999;
    end
    tick;
    coef_we = 1'b0;
    if (!hold) sample_valid = 1'b0;
    if (idle_we) exp_coef[3] = 21'd999;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    acc_in = acc;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mac_a !== hist[k] || mac_b !== exp_coef[k]) begin
        failures++;
        $display("FAIL %s tap%0d operands: a=%0d b=%0d, expected a=%0d b=%0d", tag, k, mac_a, mac_b, hist[k], exp_coef[k]);
      end
      checks++;
      if (sample_ready !== 1'b0 || mac_clr !== 1'b0 || y_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s tap%0d run ctrl: ready=%b clr=%b yv=%b, expected 0 0 0", tag, k, sample_ready, mac_clr, y_valid);
      end
      if (run_we && k == 1) begin
        coef_we = 1'b1; coef_addr = 3'd3; coef_data = 21'd999;
      end else coef_we = 1'b0;
      tick;
    end
    coef_we = 1'b0;
    checks++;
    if ({sample_ready, mac_clr, mac_a, mac_b, y_valid} !== {1'b0, 1'b1, {DATA_W{1'b0}}, {DATA_W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL %s drain: ready=%b clr=%b a=%0d b=%0d yv=%b, expected 0 1 0 0 0", tag, sample_ready, mac_clr, mac_a, mac_b, y_valid);
    end
    tick;
    checks++;
    if (y_valid !== 1'b1 || y_out !== acc || sample_ready !== 1'b1 || mac_clr !== 1'b1) begin
      failures++;
      $display("FAIL %s capture: yv=%b y=%h ready=%b clr=%b, expected yv=1 y=%h ready=1 clr=1", tag, y_valid, y_out, sample_ready, mac_clr, acc);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    check_idle_outputs("reset_state", '0, 1'b0);
    reset = 1'b0;
    tick;
    check_idle_outputs("after_reset_idle", '0, 1'b0);
  endtask
  task automatic load_coefs;
    for (int k = 0; k < 8; k++) begin
      coef_we = 1'b1; coef_addr = 3'(k); coef_data = 21'(k + 1);
      exp_coef[k] = 21'(k + 1);
      tick;
    end
    coef_we = 1'b0;
  endtask
  task automatic test_impulse;
    for (int f = 1; f <= 9; f++)
      frame((f == 1) ? 21'd100 : 21'd0, 25'(f * 1000), 1'b0, 1'b0, 1'b0, $sformatf("impulse_f%0d", f));
  endtask
  task automatic test_capture;
    frame(21'd5, 25'h1ABCDEF, 1'b0, 1'b0, 1'b0, "capture");
    acc_in = 25'h0000123;
    tick;
    check_idle_outputs("capture_hold1", 25'h1ABCDEF, 1'b0);
    tick;
    check_idle_outputs("capture_hold2", 25'h1ABCDEF, 1'b0);
  endtask
  task automatic test_back_to_back;
    frame(21'd1, 25'h0000011, 1'b1, 1'b0, 1'b0, "b2b_1");
    frame(21'd2, 25'h0000022, 1'b1, 1'b0, 1'b0, "b2b_2");
    frame(21'd3, 25'h0000033, 1'b0, 1'b0, 1'b0, "b2b_3");
    tick;
    check_idle_outputs("b2b_idle", 25'h0000033, 1'b0);
  endtask
  task automatic test_coef_write;
    frame(21'd7, 25'h0000077, 1'b0, 1'b0, 1'b1, "coef_run_write");
    frame(21'd8, 25'h0000088, 1'b0, 1'b1, 1'b0, "coef_idle_write");
  endtask
  task automatic test_reset_mid;
    bit saw_valid = 1'b0;
    sample_in = 21'd55;
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    repeat (4) tick;
    checks++;
    if (mac_clr !== 1'b0 || mac_a !== hist[3] || mac_b !== exp_coef[4]) begin
      failures++;
      $display("FAIL mid_tap4: clr=%b a=%0d b=%0d, expected clr=0 a=%0d b=%0d", mac_clr, mac_a, mac_b, hist[3], exp_coef[4]);
    end
    acc_in = 25'h1555555;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_idle_outputs("mid_reset_outputs", '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      hist[i] = '0;
      exp_coef[i] = '0;
    end
    for (int i = 0; i < 12; i++) begin
      if (y_valid !== 1'b0) saw_valid = 1'b1;
      tick;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL mid_reset_no_yvalid: y_valid=1 seen, expected 0");
    end
    frame(21'd77, 25'h0000777, 1'b0, 1'b0, 1'b0, "after_mid_reset");
  endtask
  initial begin
    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    acc_in = '0;
    for (int i = 0; i < 8; i++) begin
      hist[i] = '0;
      exp_coef[i] = '0;
    end
    test_reset;
    load_coefs;
    test_impulse;
    test_capture;
    test_back_to_back;
    test_coef_write;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
